// File: rtl/alu_frame_sequencer_if.sv
// Byte-stream and ALU-operand bundle for alu_frame_sequencer.
// master = sequencer, slave = UART pair plus ALU.
interface alu_frame_sequencer_if #(
  parameter int LEN_DATA = 8,
  parameter int LEN_OP   = 6
);
  logic                rx_done_tick;
  logic [LEN_DATA-1:0] rx_data;
  logic [LEN_DATA-1:0] alu_result;
  logic                tx_done_tick;
  logic                tx_start;
  logic [LEN_DATA-1:0] tx_data;
  logic [LEN_DATA-1:0] A;
  logic [LEN_DATA-1:0] B;
  logic [LEN_OP-1:0]   OPCODE;
  logic                busy;
  logic                timeout_err;

  modport master (
    input  rx_done_tick, rx_data, alu_result, tx_done_tick,
    output tx_start, tx_data, A, B, OPCODE, busy, timeout_err
  );

  modport slave (
    output rx_done_tick, rx_data, alu_result, tx_done_tick,
    input  tx_start, tx_data, A, B, OPCODE, busy, timeout_err
  );
endinterface

// File: rtl/alu_frame_sequencer.sv
// Framed command sequencer: SYNC,OP,A,B,CHK in; result+status out.
// Transmit paced by tx_done_tick; stalled frames dropped by timeout.
module alu_frame_sequencer #(
  parameter int          LEN_DATA       = 8,
  parameter int          LEN_OP         = 6,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  STAT_OK        = 8'h00,
  parameter logic [7:0]  STAT_CHK_ERR   = 8'hE1,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input logic                  clk,
  input logic                  reset,
  alu_frame_sequencer_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    GET_OP,
    GET_A,
    GET_B,
    GET_CHK,
    EXEC,
    SEND_RES,
    WAIT_RES,
    SEND_STAT,
    WAIT_STAT
  } state_t;

  state_t              state;
  logic [LEN_DATA-1:0] op_s;
  logic [LEN_DATA-1:0] a_s;
  logic [LEN_DATA-1:0] b_s;
  logic [CW-1:0]       cnt;
  logic                tx_start_q;
  logic [LEN_DATA-1:0] tx_data_q;
  logic [LEN_DATA-1:0] a_q;
  logic [LEN_DATA-1:0] b_q;
  logic [LEN_OP-1:0]   op_q;
  logic                busy_q;
  logic                timeout_q;

  logic in_get;
  logic expire;
  logic rx;
  logic chk_ok;

  assign in_get = (state == GET_OP) || (state == GET_A) ||
                  (state == GET_B)  || (state == GET_CHK);
  assign expire = (cnt == TO_LAST);
  assign rx     = bus.rx_done_tick;
  assign chk_ok = (bus.rx_data == (op_s ^ a_s ^ b_s));

  // Frame FSM with registered handshake, operand and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      op_s       <= '0;
      a_s        <= '0;
      b_s        <= '0;
      cnt        <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      if (in_get) begin
        cnt <= rx ? '0 : cnt + 1'b1;
      end
      if (in_get && !rx && expire) begin
        state     <= IDLE;
        busy_q    <= 1'b0;
        timeout_q <= 1'b1;
        cnt       <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rx && bus.rx_data == LEN_DATA'(SYNC_BYTE)) begin
              state  <= GET_OP;
              busy_q <= 1'b1;
              cnt    <= '0;
            end
          end
          GET_OP: begin
            if (rx) begin
              op_s  <= bus.rx_data;
              state <= GET_A;
            end
          end
          GET_A: begin
            if (rx) begin
              a_s   <= bus.rx_data;
              state <= GET_B;
            end
          end
          GET_B: begin
            if (rx) begin
              b_s   <= bus.rx_data;
              state <= GET_CHK;
            end
          end
          GET_CHK: begin
            if (rx) begin
              if (chk_ok) begin
                state <= EXEC;
              end else begin
                tx_data_q  <= LEN_DATA'(STAT_CHK_ERR);
                tx_start_q <= 1'b1;
                state      <= WAIT_STAT;
              end
            end
          end
          EXEC: begin
            a_q   <= a_s;
            b_q   <= b_s;
            op_q  <= op_s[LEN_OP-1:0];
            state <= SEND_RES;
          end
          SEND_RES: begin
            tx_data_q  <= bus.alu_result;
            tx_start_q <= 1'b1;
            state      <= WAIT_RES;
          end
          WAIT_RES: begin
            if (bus.tx_done_tick) begin
              tx_data_q  <= LEN_DATA'(STAT_OK);
              tx_start_q <= 1'b1;
              state      <= WAIT_STAT;
            end
          end
          SEND_STAT: begin
            tx_data_q  <= LEN_DATA'(STAT_OK);
            tx_start_q <= 1'b1;
            state      <= WAIT_STAT;
          end
          WAIT_STAT: begin
            if (bus.tx_done_tick) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.OPCODE      = op_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Directed bench for alu_frame_sequencer with UART and ALU models.
// Frame vectors from a table plus timeout, drop and reset sequences.
module tb_alu_frame_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_frame_sequencer_if bus ();

  alu_frame_sequencer #(
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.alu_result = (bus.OPCODE == 6'h20) ? bus.A + bus.B : 8'h00;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_tx = 0;
  int to_cnt = 0;
  int t_to = 0;
  int cd = 0;
  int t_last = 0;
  logic [7:0] tx_log[$];
  int tx_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: log each byte, answer done ~20 cycles later.
  always @(negedge clk) begin
    if (!reset) begin
      cd <= 0;
      bus.tx_done_tick <= 1'b0;
    end else begin
      bus.tx_done_tick <= 1'b0;
      if (bus.tx_start) begin
        tx_log.push_back(bus.tx_data);
        tx_t.push_back(cyc);
        n_tx <= n_tx + 1;
        cd <= 20;
      end else if (cd == 1) begin
        bus.tx_done_tick <= 1'b1;
        cd <= 0;
      end else if (cd > 0) begin
        cd <= cd - 1;
      end
      if (bus.timeout_err) begin
        to_cnt <= to_cnt + 1;
        t_to <= cyc;
      end
    end
  end

  typedef struct {
    logic [7:0] by[8];
    int         n;
    int         ntx;
    logic [7:0] tx0;
    logic [7:0] tx1;
    int         lat;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  vec_t tv[5];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_data = b;
    bus.rx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_done_tick = 1'b0;
    t_last = cyc;
    tick(2);
  endtask

  task automatic wait_idle(string name);
    int i;
    for (i = 0; i < 300 && bus.busy; i++) tick(1);
    check(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_tx(string name, int base);
    int i;
    for (i = 0; i < 60 && n_tx <= base; i++) tick(1);
    check(name, 32'(n_tx > base), 32'd1);
  endtask

  task automatic run_vec(int k);
    int base;
    int t_chk;
    base = n_tx;
    for (int j = 0; j < tv[k].n; j++) send_byte(tv[k].by[j]);
    t_chk = t_last - 2;
    t_chk = t_last;
    wait_idle($sformatf("v%0d_idle", k));
    check($sformatf("v%0d_ntx", k), 32'(n_tx - base), 32'(tv[k].ntx));
    if (n_tx > base) begin
      check($sformatf("v%0d_tx0", k), 32'(tx_log[base]), 32'(tv[k].tx0));
      check($sformatf("v%0d_lat", k), 32'(tx_t[base] - t_chk),
            32'(tv[k].lat));
    end
    if (tv[k].ntx == 2 && n_tx > base + 1)
      check($sformatf("v%0d_tx1", k), 32'(tx_log[base+1]), 32'(tv[k].tx1));
    check($sformatf("v%0d_op", k), 32'(bus.OPCODE), 32'(tv[k].op[5:0]));
    check($sformatf("v%0d_a", k), 32'(bus.A), 32'(tv[k].a));
    check($sformatf("v%0d_b", k), 32'(bus.B), 32'(tv[k].b));
  endtask

  initial begin
    int base;
    int to0;
    int t20;

    tv[0] = '{by: '{8'hA5, 8'h20, 8'h05, 8'h03, 8'h26, 0, 0, 0}, n: 5,
              ntx: 2, tx0: 8'h08, tx1: 8'h00, lat: 2,
              op: 8'h20, a: 8'h05, b: 8'h03};
    tv[1] = '{by: '{8'hA5, 8'h22, 8'h0F, 8'h01, 8'h00, 0, 0, 0}, n: 5,
              ntx: 1, tx0: 8'hE1, tx1: 8'h00, lat: 0,
              op: 8'h20, a: 8'h05, b: 8'h03};
    tv[2] = '{by: '{8'hA5, 8'h20, 8'h10, 8'h22, 8'h12, 0, 0, 0}, n: 5,
              ntx: 2, tx0: 8'h32, tx1: 8'h00, lat: 2,
              op: 8'h20, a: 8'h10, b: 8'h22};
    tv[3] = '{by: '{8'hA5, 8'h20, 8'hA5, 8'h01, 8'h84, 0, 0, 0}, n: 5,
              ntx: 2, tx0: 8'hA6, tx1: 8'h00, lat: 2,
              op: 8'h20, a: 8'hA5, b: 8'h01};
    tv[4] = '{by: '{8'hA5, 8'h60, 8'h01, 8'h02, 8'h63, 0, 0, 0}, n: 5,
              ntx: 2, tx0: 8'h03, tx1: 8'h00, lat: 2,
              op: 8'h20, a: 8'h01, b: 8'h02};

    bus.rx_done_tick = 1'b0;
    bus.rx_data = 8'h00;
    tick(3);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_A", 32'(bus.A), 32'd0);
    check("rst_B", 32'(bus.B), 32'd0);
    check("rst_OPCODE", 32'(bus.OPCODE), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    reset = 1'b1;
    tick(3);

    for (int k = 0; k < 5; k++) run_vec(k);

    send_byte(8'h11);
    send_byte(8'h5A);
    check("garbage_busy", 32'(bus.busy), 32'd0);
    run_vec(0);

    base = n_tx;
    to0 = to_cnt;
    send_byte(8'hA5);
    send_byte(8'h20);
    t20 = t_last;
    tick(60);
    check("to_pulses", 32'(to_cnt - to0), 32'd1);
    check("to_delay", 32'(t_to - t20), 32'd50);
    check("to_busy", 32'(bus.busy), 32'd0);
    check("to_no_tx", 32'(n_tx - base), 32'd0);
    run_vec(0);

    base = n_tx;
    for (int j = 0; j < 5; j++) send_byte(tv[2].by[j]);
    wait_tx("drop_wait", base);
    send_byte(8'h77);
    send_byte(8'hA5);
    wait_idle("drop_idle");
    check("drop_ntx", 32'(n_tx - base), 32'd2);
    if (n_tx >= base + 2) begin
      check("drop_tx0", 32'(tx_log[base]), 32'h32);
      check("drop_tx1", 32'(tx_log[base+1]), 32'h00);
    end
    tick(3);
    check("drop_still_idle", 32'(bus.busy), 32'd0);
    run_vec(3);

    base = n_tx;
    for (int j = 0; j < 5; j++) send_byte(tv[0].by[j]);
    wait_tx("rst_wait", base);
    tick(3);
    reset = 1'b0;
    #1;
    check("arst_tx_start", 32'(bus.tx_start), 32'd0);
    check("arst_tx_data", 32'(bus.tx_data), 32'd0);
    check("arst_A", 32'(bus.A), 32'd0);
    check("arst_B", 32'(bus.B), 32'd0);
    check("arst_OPCODE", 32'(bus.OPCODE), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(60);
    check("arst_no_stat", 32'(n_tx - base), 32'd1);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_frame_sequencer.md
Name: alu_frame_sequencer

Overview:
- Framed command controller between the UART receive/transmit pair and the combinational ALU.
- Collects a 5-byte frame from the UART receiver: SYNC, OPCODE, A, B, CHK.
- Checks an XOR checksum, then commits operands to the ALU and returns the result byte followed by a status byte.
- Paces every transmit on the UART tx_done_tick handshake and drops stalled frames with an inter-byte timeout.

Parameters:
- LEN_DATA, 8, width of UART data, operands and result.
- LEN_OP, 6, ALU opcode width; LEN_OP <= LEN_DATA.
- SYNC_BYTE, 8'hA5, frame start marker.
- STAT_OK, 8'h00, status byte for an executed frame.
- STAT_CHK_ERR, 8'hE1, status byte for a checksum failure.
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between frame bytes (10 ms at 100 MHz).

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- rx_done_tick, input, 1, one-cycle pulse: rx_data is valid.
- rx_data, input, LEN_DATA, byte received by the UART.
- alu_result, input, LEN_DATA, combinational ALU output.
- tx_done_tick, input, 1, one-cycle pulse: the UART has finished sending a byte.
- tx_start, output, 1, one-cycle request to transmit tx_data.
- tx_data, output, LEN_DATA, byte to transmit.
- A, output, LEN_DATA, committed ALU operand A.
- B, output, LEN_DATA, committed ALU operand B.
- OPCODE, output, LEN_OP, committed ALU opcode.
- busy, output, 1, high in every state except IDLE.
- timeout_err, output, 1, one-cycle pulse when a frame is abandoned on timeout.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. tx_start, tx_data, A, B, OPCODE, busy and timeout_err all 0. Shadow registers and timeout counter cleared. A reset mid-frame or mid-transmit aborts with no further tx_start.
- States: IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, SEND_RES, WAIT_RES, SEND_STAT, WAIT_STAT.
- IDLE: on rx_done_tick with rx_data==SYNC_BYTE go to GET_OP. Any other byte is discarded and the state stays IDLE.
- GET_OP, GET_A, GET_B: on rx_done_tick capture rx_data into shadow op_s, a_s or b_s and advance. SYNC_BYTE inside a frame is ordinary data.
- GET_CHK: on rx_done_tick compare rx_data against op_s ^ a_s ^ b_s over the full byte, including opcode upper bits.
  - Match: go to EXEC.
  - Mismatch: tx_data<=STAT_CHK_ERR, tx_start<=1, go to WAIT_STAT. No result byte is sent; A, B and OPCODE are unchanged.
- Timeout:
  - Counter clears on entry to GET_OP and on every accepted byte; it increments each cycle in the GET_* states.
  - When it reaches TIMEOUT_CYCLES-1 without rx_done_tick: go to IDLE and pulse timeout_err for 1 cycle.
  - If rx_done_tick and expiry occur in the same cycle, the byte wins.
- EXEC (1 cycle): A<=a_s, B<=b_s, OPCODE<=op_s[LEN_OP-1:0], go to SEND_RES.
- SEND_RES (1 cycle, ALU settled): tx_data<=alu_result, tx_start<=1, go to WAIT_RES.
- Latency: CHK rx_done_tick sampled at edge k gives operands committed at edge k+1 and tx_start high during cycle k+3.
- WAIT_RES: on tx_done_tick, tx_data<=STAT_OK, tx_start<=1, go to WAIT_STAT.
- WAIT_STAT: on tx_done_tick go to IDLE. No transmit timeout applies.
- tx_start is high for exactly 1 cycle per byte. It is never re-asserted before the tx_done_tick of the previous byte.
- rx_done_tick in EXEC, SEND_RES, WAIT_RES or WAIT_STAT is dropped. It never starts a new frame.
- tx_done_tick outside WAIT_RES and WAIT_STAT is ignored.
- tx_data holds its value between transmissions.

Test Plan:
- Bench setup: TIMEOUT_CYCLES=50; ALU model is OPCODE 0x20 = A+B; UART model returns tx_done_tick 20 cycles after tx_start.
- Valid frame A5,20,05,03,26 -> OPCODE=0x20, A=0x05, B=0x03. tx bytes 0x08 then 0x00. tx_start pulses exactly twice, first pulse 3 cycles after the CHK tick. busy falls after the 2nd tx_done_tick.
- After the valid frame, bad frame A5,22,0F,01,00 -> only 0xE1 is transmitted. A, B and OPCODE stay 05, 03, 20.
- Garbage 11,5A then the valid frame -> garbage ignored, busy stays 0 until A5, then 08,00 transmitted.
- A5,20 then silence for 60 cycles -> timeout_err pulses once, 50 cycles after the 0x20 tick. busy=0, no tx_start. A subsequent valid frame responds correctly.
- Bytes 77,A5 injected during WAIT_RES -> both dropped, status 0x00 still sent, state returns to IDLE. The next frame is parsed normally.
- reset=0 asserted during WAIT_RES -> tx_start, tx_data, A, B, OPCODE and busy go to 0 immediately, with no status byte after release. A valid frame afterwards works.
